// File: rtl/mcycle_pkg.sv
// rtl/mcycle_pkg.sv - shared encodings and types for the multi-cycle mul/div unit
package mcycle_pkg;

  // MCycleOp bit positions and the bit values that select each mode
  localparam int   OP_DIV_BIT    = 0;
  localparam int   OP_SIGNED_BIT = 1;
  localparam logic OP_MUL        = 1'b0;
  localparam logic OP_DIV        = 1'b1;
  localparam logic OP_SIGNED     = 1'b1;

  // Divide by zero returns a quotient with every bit set to this value
  localparam logic DIV_ZERO_FILL = 1'b1;

  typedef enum logic {
    IDLE      = 1'b0,
    COMPUTING = 1'b1
  } state_t;

endpackage

// File: rtl/mcycle_sign_adjust.sv
// rtl/mcycle_sign_adjust.sv - conditional two's-complement negate
module mcycle_sign_adjust #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? ((~value) + WIDTH'(1)) : value;

endmodule

// File: rtl/mcycle_unit.sv
// rtl/mcycle_unit.sv - radix-2 iterative multiply/divide unit with stall output
module mcycle_unit
  import mcycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t             state, state_nxt;
  logic [CW-1:0]      count;
  logic               is_div, neg_q, neg_r, div_zero, div_ovf;
  logic [WIDTH-1:0]   op_x, raw_op1;
  logic [2*WIDTH-1:0] acc, acc_nxt;

  logic               accept, last_iter;
  logic               in_signed, in_div, sign1, sign2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   res1_nxt, res2_nxt;

  assign accept    = (state == IDLE) && Start;
  assign last_iter = (count == CW'(WIDTH - 1));
  assign Busy      = RESETn && (accept || (state == COMPUTING));

  assign in_signed = (MCycleOp[OP_SIGNED_BIT] == OP_SIGNED);
  assign in_div    = (MCycleOp[OP_DIV_BIT] == OP_DIV);
  assign sign1     = in_signed && Operand1[WIDTH-1];
  assign sign2     = in_signed && Operand2[WIDTH-1];

  mcycle_sign_adjust #(.WIDTH(WIDTH)) u_mag1 (.value(Operand1), .negate(sign1), .result(mag1));
  mcycle_sign_adjust #(.WIDTH(WIDTH)) u_mag2 (.value(Operand2), .negate(sign2), .result(mag2));

  // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op_x} : '0);
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, op_x};

  always_comb begin
    acc_nxt = acc;
    if (is_div) begin
      if (div_diff[WIDTH])
        acc_nxt = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        acc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  mcycle_sign_adjust #(.WIDTH(2*WIDTH)) u_prod (.value(acc_nxt), .negate(neg_q), .result(prod_fix));
  mcycle_sign_adjust #(.WIDTH(WIDTH)) u_quo (.value(acc_nxt[WIDTH-1:0]), .negate(neg_q), .result(quo_fix));
  mcycle_sign_adjust #(.WIDTH(WIDTH)) u_rem (.value(acc_nxt[2*WIDTH-1:WIDTH]), .negate(neg_r), .result(rem_fix));

  always_comb begin
    res1_nxt = prod_fix[WIDTH-1:0];
    res2_nxt = prod_fix[2*WIDTH-1:WIDTH];
    if (is_div) begin
      if (div_zero) begin
        res1_nxt = {WIDTH{DIV_ZERO_FILL}};
        res2_nxt = raw_op1;
      end else if (div_ovf) begin
        res1_nxt = {1'b1, {(WIDTH-1){1'b0}}};
        res2_nxt = '0;
      end else begin
        res1_nxt = quo_fix;
        res2_nxt = rem_fix;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (Start) state_nxt = COMPUTING;
      COMPUTING: if (last_iter) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      count    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      op_x     <= '0;
      raw_op1  <= '0;
      acc      <= '0;
      Result1  <= '0;
      Result2  <= '0;
    end else if (accept) begin
      count    <= '0;
      is_div   <= in_div;
      neg_q    <= sign1 ^ sign2;
      neg_r    <= sign1;
      div_zero <= (Operand2 == '0);
      div_ovf  <= in_signed && (Operand1 == {1'b1, {(WIDTH-1){1'b0}}}) && (Operand2 == '1);
      op_x     <= in_div ? mag2 : mag1;
      raw_op1  <= Operand1;
      acc      <= {{WIDTH{1'b0}}, (in_div ? mag1 : mag2)};
    end else if (state == COMPUTING) begin
      count <= count + CW'(1);
      acc   <= acc_nxt;
      if (last_iter) begin
        Result1 <= res1_nxt;
        Result2 <= res2_nxt;
      end
    end
  end

endmodule

// File: tb/tb_mcycle_unit.sv
// tb/tb_mcycle_unit.sv - scoreboard bench for mcycle_unit against an arithmetic model
module tb_mcycle_unit;

  localparam int W = 32;

  logic         CLK, RESETn, Start;
  logic [1:0]   MCycleOp;
  logic [W-1:0] Operand1, Operand2, Result1, Result2;
  logic         Busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] r1;
    logic [W-1:0] r2;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   run = 0;
  bit   check_now = 0;

  mcycle_unit #(.WIDTH(W)) dut (
    .CLK(CLK), .RESETn(RESETn), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int sa, sbv;
    longint p;
    longint unsigned pu;
    sa  = a;
    sbv = b;
    if (op[0] == 1'b0) begin
      if (op[1]) begin
        p = longint'(sa) * longint'(sbv);
        {e.r2, e.r1} = p;
      end else begin
        pu = 64'(a) * 64'(b);
        {e.r2, e.r1} = pu;
      end
    end else if (b == 0) begin
      e.r1 = 32'hFFFF_FFFF;
      e.r2 = a;
    end else if (op[1]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.r1 = 32'h8000_0000;
        e.r2 = 0;
      end else begin
        e.r1 = sa / sbv;
        e.r2 = sa % sbv;
      end
    end else begin
      e.r1 = a / b;
      e.r2 = a % b;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: a Busy run of W+1 cycles marks one completed operation
  always @(negedge CLK) begin
    if (!RESETn) begin
      run       = 0;
      check_now = 0;
    end else begin
      if (check_now) begin
        check_now = 0;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result actual=%h_%h required=none", Result2, Result1);
        end else begin
          mon_e = sb.pop_front();
          check("result1", Result1, mon_e.r1);
          check("result2", Result2, mon_e.r2);
        end
      end
      if (Busy) begin
        run++;
        if (run == W + 1) begin
          check_now = 1;
          run = 0;
        end
      end else if (run != 0) begin
        total++;
        bad++;
        $display("FAIL busy_length actual=%0d required=%0d", run, W + 1);
        run = 0;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge CLK); #1;
    Start    = 1'b1;
    MCycleOp = op;
    Operand1 = a;
    Operand2 = b;
    sb.push_back(model(op, a, b));
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit noise);
    issue(op, a, b);
    @(posedge CLK); #1;
    Start = 1'b0;
    for (int i = 0; i < W; i++) begin
      @(posedge CLK); #1;
      if (noise && i < W - 1) begin
        Start    = 1'($urandom);
        MCycleOp = 2'($urandom);
        Operand1 = $urandom;
        Operand2 = $urandom;
      end else begin
        Start = 1'b0;
      end
    end
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] specials [5];
    specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 300)) - 32'd150;
    return $urandom;
  endfunction

  initial begin
    RESETn   = 1'b0;
    Start    = 1'b1;
    MCycleOp = 2'b00;
    Operand1 = 32'd5;
    Operand2 = 32'd6;
    #2;
    check("reset_busy", {31'b0, Busy}, 32'd0);
    check("reset_result1", Result1, 32'd0);
    check("reset_result2", Result2, 32'd0);
    Start = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    RESETn = 1'b1;

    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(2'b10, 32'hFFFF_FFFD, 32'd7, 1);
    do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(2'b01, 32'd100, 32'd7, 1);
    do_op(2'b01, 32'd100, 32'd0, 0);
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(2'b11, 32'd100, 32'd0, 0);

    // Mid-operation Start pulse with new operands must be ignored
    issue(2'b00, 32'd5, 32'd6);
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    Start    = 1'b1;
    Operand1 = 32'd9;
    Operand2 = 32'd9;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (W - 11) @(posedge CLK);
    #1;

    // Start held high across completion launches the next operation at once
    issue(2'b10, 32'd12345, 32'hFFFF_FF00);
    repeat (W) @(posedge CLK);
    #1;
    MCycleOp = 2'b01;
    Operand1 = 32'd1000;
    Operand2 = 32'd33;
    sb.push_back(model(2'b01, 32'd1000, 32'd33));
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (W) @(posedge CLK);
    #1;

    // Asynchronous reset mid-operation
    issue(2'b00, 32'd5, 32'd6);
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (10) @(posedge CLK);
    #2;
    RESETn = 1'b0;
    #1;
    check("midreset_busy", {31'b0, Busy}, 32'd0);
    check("midreset_result1", Result1, 32'd0);
    check("midreset_result2", Result2, 32'd0);
    sb.delete();
    @(posedge CLK); #1;
    RESETn = 1'b1;
    do_op(2'b00, 32'd2, 32'd3, 0);

    for (int n = 0; n < 40; n++)
      do_op(2'($urandom), pick(), pick(), 1'($urandom));

    for (int i = 0; i < 200 && (sb.size() != 0 || check_now); i++) @(posedge CLK);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mcycle_unit.md
Name: mcycle_unit

Overview:
- Iterative multi-cycle multiply/divide execution unit in the single-cycle ARM datapath, downstream of the control unit.
- Consumes the control unit's Start/MCycleOp decode and the register-file operands. Produces a two-word result for write-back.
- While an operation runs it holds the core stalled through Busy.
- Radix-2: one shift-add (multiply) or one restoring shift-subtract (divide) step per clock.

Parameters:
- WIDTH, 32, operand and result word width; must be ≥ 4.

Ports:
- CLK  in  1  system clock, all state updates on rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- Start  in  1  request a new operation; sampled only in IDLE.
- MCycleOp  in  2  [0]: 0 = multiply, 1 = divide. [1]: 1 = signed, 0 = unsigned.
- Operand1  in  WIDTH  multiplicand / dividend.
- Operand2  in  WIDTH  multiplier / divisor.
- Result1  out  WIDTH  multiply: product low word; divide: quotient.
- Result2  out  WIDTH  multiply: product high word; divide: remainder.
- Busy  out  1  high while the core must stall.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low.
- RESETn low forces, immediately and without a clock: state = IDLE, iteration count = 0, Result1 = 0, Result2 = 0, Busy = 0.
- Reset mid-operation aborts the operation; no partial result is ever exposed.
- States:
  - IDLE → COMPUTING on a rising edge with Start = 1.
  - COMPUTING → IDLE on the edge that completes iteration WIDTH.
  - No other transitions.
- Accepting an operation: on the accept edge, latch MCycleOp, the operand magnitudes (signed mode) or raw operands (unsigned), and the result signs. Clear the iteration count.
- Operands and MCycleOp are ignored after acceptance. Changing them mid-operation has no effect.
- Busy is combinational: (state == IDLE && Start) || state == COMPUTING.
  - The core therefore stalls in the same cycle Start is raised.
  - Busy is high for exactly WIDTH+1 consecutive cycles per operation.
- Start while COMPUTING is ignored; it is not queued.
- Start held high continuously starts a new operation on the first edge after returning to IDLE.
- Multiply:
  - 2*WIDTH-bit accumulator, shift-add on the multiplier LSB each iteration.
  - Result = full 2*WIDTH-bit product, split low → Result1, high → Result2.
  - Signed multiply: product of the magnitudes, negated in two's complement over 2*WIDTH bits if the operand signs differ.
- Divide:
  - Restoring algorithm, WIDTH iterations, quotient bit per iteration.
  - Signed divide: quotient truncates toward zero and is negative iff the signs differ; remainder takes the dividend's sign.
  - Divide by zero (both modes): Result1 = all ones, Result2 = Operand1 as latched.
  - Signed overflow (most-negative / -1): Result1 = most-negative value, Result2 = 0.
- Output timing:
  - Result1/Result2 are registered and update only on the completion edge, together with the COMPUTING → IDLE transition.
  - They hold that value until the next completion or reset.
  - Results are readable in the first cycle Busy is low after the operation.
- Iteration counter: clog2(WIDTH)+1 bits, no wrap within an operation.

Decomposition:
- Shared package (mcycle_pkg) holds:
  - MCycleOp bit positions and encodings: OP_MUL, OP_DIV, OP_SIGNED.
  - State enum: IDLE, COMPUTING.
  - The divide-by-zero result constant.
  The decoder uses the same encodings when generating MCycleOp.
- One sub-module is natural: mcycle_sign_adjust.
  - Combinational conditional two's-complement negate, parameterised width.
  - Used for operand magnitude extraction and final result sign correction.
- The iterative datapath and FSM stay in mcycle_unit.

Test Plan:
- Unsigned multiply, 0xFFFFFFFF × 0xFFFFFFFF → Result1 = 0x00000001, Result2 = 0xFFFFFFFE; Busy high exactly 33 cycles starting in the Start cycle.
- Signed multiply, -3 × 7 → Result1 = 0xFFFFFFEB, Result2 = 0xFFFFFFFF.
- Signed divide, -7 / 2 → Result1 = 0xFFFFFFFD, Result2 = 0xFFFFFFFF. Unsigned 100 / 7 → Result1 = 14, Result2 = 2.
- Divide by zero, unsigned 100 / 0 → Result1 = 0xFFFFFFFF, Result2 = 0x00000064. Signed 0x80000000 / -1 → Result1 = 0x80000000, Result2 = 0.
- Start 5 × 6, then pulse Start and change operands to 9 × 9 at iteration 10 → result 30 with Busy still 33 cycles; no second operation begins.
- Assert RESETn low mid-operation at iteration 10 → Busy, Result1, Result2 = 0 with no clock edge. Release, then a fresh Start 2 × 3 → 6 after 33 Busy cycles.
